floor_uart_reporter: RTL and testbench

//  Serialises the two ASCII floor digits from the segment encoder into an 8N1 UART frame.

---
 rtl/floor_uart_reporter.sv | 136 +++++++++++++
 tb/tb_floor_uart_reporter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/floor_uart_reporter.sv
// 8N1 UART reporter: sends high digit, low digit, CR, LF LSB-first
// whenever the digit pair changes or a resend is requested.
module floor_uart_reporter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] asciiHigh,
  input  logic [7:0] asciiLow,
  input  logic       forceSend,
  output logic       txd,
  output logic       busy,
  output logic       frameDone
);

  localparam int BYTES = 4;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [15:0]   frame_buf;
  logic [15:0]   last_sent;
  logic          pending;
  logic [7:0]    cur_byte;
  logic [15:0]   pair;
  logic          trigger;
  logic          bit_end;
  logic [2:0]    next_bit;

  assign pair     = {asciiHigh, asciiLow};
  assign trigger  = (pair != last_sent) | forceSend | pending;
  assign bit_end  = (cnt == LAST_CNT);
  assign next_bit = bit_idx + 3'd1;

  always_comb begin
    cur_byte = 8'h0A;
    unique case (byte_idx)
      2'd0: cur_byte = frame_buf[15:8];
      2'd1: cur_byte = frame_buf[7:0];
      2'd2: cur_byte = 8'h0D;
      2'd3: cur_byte = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      frame_buf <= 16'h3030;
      last_sent <= 16'h3030;
      pending   <= 1'b0;
      txd       <= 1'b1;
      busy      <= 1'b0;
      frameDone <= 1'b0;
    end else begin
      // resend requests outside IDLE collapse into one pending flag
      if (state != IDLE && forceSend)
        pending <= 1'b1;
      unique case (state)
        IDLE: begin
          txd       <= 1'b1;
          busy      <= 1'b0;
          frameDone <= 1'b0;
          if (trigger) begin
            frame_buf <= pair;
            last_sent <= pair;
            pending   <= 1'b0;
            byte_idx  <= '0;
            cnt       <= '0;
            txd       <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt     <= '0;
            bit_idx <= '0;
            txd     <= cur_byte[0];
            state   <= DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= next_bit;
              txd     <= cur_byte[next_bit];
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (byte_idx == LAST_BYTE) begin
              busy      <= 1'b0;
              frameDone <= 1'b1;
              txd       <= 1'b1;
              state     <= DONE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              txd      <= 1'b0;
              state    <= START;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          frameDone <= 1'b0;
          txd       <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floor_uart_reporter.sv
// Scoreboard bench for floor_uart_reporter: frame-level reference model
// feeds expected bytes; a UART receiver pops and compares them.
module tb_floor_uart_reporter;

  localparam int CPB = 4;
  localparam int FRAME = 40 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] asciiHigh = 8'h30;
  logic [7:0] asciiLow = 8'h30;
  logic       forceSend = 1'b0;
  logic       txd;
  logic       busy;
  logic       frameDone;

  int errors = 0;
  int checks = 0;

  floor_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .asciiHigh(asciiHigh),
    .asciiLow(asciiLow),
    .forceSend(forceSend),
    .txd(txd),
    .busy(busy),
    .frameDone(frameDone)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a frame occupies FRAME busy cycles plus one DONE
  // cycle; while occupied, requests only leave a single pending resend.
  logic [15:0] m_last;
  bit          m_pend;
  int          m_remain;
  logic [7:0]  exp_q[$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last = 16'h3030;
      m_pend = 1'b0;
      m_remain = 0;
      exp_q.delete();
    end else if (m_remain > 0) begin
      m_remain--;
      if (forceSend) m_pend = 1'b1;
    end else if ({asciiHigh, asciiLow} != m_last || forceSend || m_pend) begin
      exp_q.push_back(asciiHigh);
      exp_q.push_back(asciiLow);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
      m_last = {asciiHigh, asciiLow};
      m_pend = 1'b0;
      m_remain = FRAME + 1;
    end
  end

  // line-level status checks, sampled mid-cycle
  always @(negedge clk) begin
    if (!reset) begin
      check(busy == (m_remain >= 2), "busy", busy, m_remain >= 2);
      check(frameDone == (m_remain == 1), "frameDone", frameDone,
            m_remain == 1);
      if (m_remain <= 1)
        check(txd == 1'b1, "idle_txd", txd, 1);
      if (m_remain == FRAME + 1)
        check(txd == 1'b0, "start_latency", txd, 0);
    end
  end

  // UART receiver / scoreboard monitor
  bit       rx_active = 1'b0;
  int       rx_cnt = 0;
  logic [7:0] rx_byte;
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (reset) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (!txd) begin
        rx_active = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == 0) begin
        if (rx_cnt / CPB <= 8) begin
          rx_byte[rx_cnt / CPB - 1] = txd;
        end else begin
          rx_active = 1'b0;
          check(txd == 1'b1, "stop_bit", txd, 1);
          if (exp_q.size() == 0) begin
            check(1'b0, "unexpected_byte", rx_byte, 0);
          end else begin
            exp_b = exp_q.pop_front();
            check(rx_byte == exp_b, "rx_byte", rx_byte, exp_b);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_force();
    forceSend = 1'b1;
    step(1);
    forceSend = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    reset = 1'b1;
    #1;
    check(txd == 1'b1, "reset_txd", txd, 1);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(frameDone == 1'b0, "reset_frameDone", frameDone, 0);
    step(hold);
    reset = 1'b0;
  endtask

  initial begin
    step(1);
    do_reset(3);
    // hold the reset pair: line must stay idle
    step(500);
    // single frame on pair change
    asciiLow = 8'h33;
    step(200);
    // pair changes while byte 1 is in flight
    asciiLow = 8'h34;
    step(CPB * 10 + 5);
    asciiHigh = 8'h31;
    asciiLow = 8'h32;
    step(400);
    // several resend pulses during one frame collapse to one resend
    pulse_force();
    step(20);
    pulse_force();
    step(30);
    pulse_force();
    step(30);
    pulse_force();
    step(450);
    // reset in the data bits of byte 2
    asciiHigh = 8'h35;
    asciiLow = 8'h36;
    step(CPB * 20 + CPB + 10);
    asciiHigh = 8'h30;
    asciiLow = 8'h30;
    do_reset(3);
    step(300);
    // force together with a new pair: one frame
    asciiHigh = 8'h37;
    asciiLow = 8'h38;
    pulse_force();
    step(300);
    // randomized traffic, any byte values
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45) begin
        asciiHigh = 8'($urandom);
        asciiLow = 8'($urandom);
      end else if (r < 75) begin
        pulse_force();
      end else if (r < 80) begin
        do_reset($urandom_range(1, 3));
      end
      step($urandom_range(1, 250));
    end
    begin
      int budget;
      budget = 0;
      while (!(m_remain == 0 && exp_q.size() == 0 && !rx_active)
             && budget < 3000) begin
        step(1);
        budget++;
      end
      check(budget < 3000, "drain_timeout", budget, 3000);
      check(exp_q.size() == 0, "leftover_bytes", exp_q.size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
